// File: rtl/red_modl_seq_pkg.sv
// Shared constants and types for the EdDSA scalar reduction path.
package eddsa_pkg;

  // Ed25519 group order L = 2^252 + 27742317777372353535851937790883648493
  localparam logic [252:0] L_Q =
    253'h1000_0000_0000_0000_0000_0000_0000_0000_14de_f9de_a2f7_9cd6_5812_631a_5cf5_d3ed;

  // Largest shift of L that still fits below 2^512
  localparam int unsigned TOP_SHIFT = 259;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/red_modl_seq_if.sv
// Request/result bundle between the digest path and the mod-L sequencer.
interface red_modl_seq_if;
  logic         start;
  logic [511:0] x_in;
  logic         busy;
  logic         done;
  logic [252:0] r_out;

  modport master (output start, output x_in, input busy, input done, input r_out);
  modport slave  (input start, input x_in, output busy, output done, output r_out);
endinterface

// File: rtl/red_modl_seq_step.sv
// One shift-and-subtract step: subtract L<<k from acc when it fits.
module modl_step
  import eddsa_pkg::*;
(
  input  logic [512:0] acc,
  input  logic [8:0]   k,
  output logic [512:0] acc_nxt,
  output logic         ge
);

  logic [512:0] t;

  // Compare against the shifted modulus and conditionally subtract
  always_comb begin
    t       = {260'b0, L_Q} << k;
    ge      = (acc >= t);
    acc_nxt = ge ? (acc - t) : acc;
  end

endmodule

// File: rtl/red_modl_seq.sv
// Reduces a 512-bit value modulo the Ed25519 order L with one
// compare/subtract step per cycle, k running from N_STEPS-1 down to 0.
// Optional: RED_MODL_EARLY_EXIT_EN leaves RUN as soon as acc < L
// (variable latency); undefined gives fixed, constant-time latency.
module red_modl_seq
  import eddsa_pkg::*;
#(
  parameter int unsigned N_STEPS = TOP_SHIFT + 1
) (
  input  logic           clk,
  input  logic           rst,
  red_modl_seq_if.slave  bus
);

  localparam logic [8:0] K_TOP = 9'(N_STEPS - 1);

  state_t       state;
  logic [512:0] acc;
  logic [8:0]   k;
  logic [512:0] acc_nxt;
  logic         ge;
  logic         busy_q;
  logic         done_q;
  logic [252:0] r_q;

  modl_step u_step (
    .acc     (acc),
    .k       (k),
    .acc_nxt (acc_nxt),
    .ge      (ge)
  );

  // Sequencer FSM with k counter, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      k      <= '0;
      r_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            acc    <= {1'b0, bus.x_in};
            k      <= K_TOP;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef RED_MODL_EARLY_EXIT_EN
          if (acc < {260'b0, L_Q}) begin
            r_q    <= acc[252:0];
            done_q <= 1'b1;
            state  <= DONE;
          end else
`endif
          begin
            acc <= acc_nxt;
            if (k == 9'd0) begin
              r_q    <= acc_nxt[252:0];
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              k <= k - 9'd1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.r_out = r_q;

endmodule
